// File: rtl/axi_xbar_aw_w_arb.sv
// AW arbiter for one crossbar master port with an in-order AW-to-W routing queue.
// Round-robin AW grant, locked until handshake; W beats follow accepted AW order.
module axi_xbar_aw_w_arb #(
    parameter int unsigned NoSlvPorts = 4,
    parameter int unsigned MaxWTrans  = 4,
    localparam int unsigned IdxW = ($clog2(NoSlvPorts) > 1) ? $clog2(NoSlvPorts) : 1,
    localparam int unsigned CntW = $clog2(MaxWTrans + 1),
    localparam int unsigned PtrW = ($clog2(MaxWTrans) > 1) ? $clog2(MaxWTrans) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NoSlvPorts-1:0] slv_aw_valid_i,
    output logic [NoSlvPorts-1:0] slv_aw_ready_o,
    input  logic [NoSlvPorts-1:0] slv_w_valid_i,
    input  logic [NoSlvPorts-1:0] slv_w_last_i,
    output logic [NoSlvPorts-1:0] slv_w_ready_o,
    output logic                  mst_aw_valid_o,
    input  logic                  mst_aw_ready_i,
    output logic [IdxW-1:0]       mst_aw_sel_o,
    output logic                  mst_w_valid_o,
    output logic                  mst_w_last_o,
    input  logic                  mst_w_ready_i,
    output logic [IdxW-1:0]       mst_w_sel_o,
    output logic [CntW-1:0]       w_cnt_o
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] rr_q;
    logic [IdxW-1:0] lock_q;
    logic [IdxW-1:0] winner;
    logic            any_valid;
    logic [IdxW:0]   pos;

    logic            aw_valid;
    logic [IdxW-1:0] aw_sel;
    logic            push;
    logic            pop;

    logic [IdxW-1:0] mem [MaxWTrans];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] cnt_q;
    logic [IdxW-1:0] head;
    logic            q_empty;
    logic            q_full;

    function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
        if (idx == IdxW'(NoSlvPorts - 1)) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
        if (ptr == PtrW'(MaxWTrans - 1)) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

    // Round-robin search starting at rr_q; pos stays below NoSlvPorts for any port count.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        pos       = '0;
        for (int unsigned off = 0; off < NoSlvPorts; off++) begin
            pos = {1'b0, rr_q} + (IdxW + 1)'(off);
            if (pos >= (IdxW + 1)'(NoSlvPorts)) begin
                pos = pos - (IdxW + 1)'(NoSlvPorts);
            end
            if (!any_valid && slv_aw_valid_i[pos[IdxW-1:0]]) begin
                any_valid = 1'b1;
                winner    = pos[IdxW-1:0];
            end
        end
    end

    assign q_empty = (cnt_q == '0);
    assign q_full  = (cnt_q == CntW'(MaxWTrans));
    assign head    = mem[rd_ptr_q];

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rr_q    <= '0;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && aw_valid && !mst_aw_ready_i) begin
                lock_q <= winner;
            end
            if (push) begin
                rr_q <= next_idx(aw_sel);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (aw_valid && !mst_aw_ready_i) state_d = HOLD;
            HOLD: if (push) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // AW outputs; fullness uses the registered count so a same-cycle pop never frees a slot
    always_comb begin
        aw_valid       = 1'b0;
        aw_sel         = '0;
        slv_aw_ready_o = '0;
        if (rst_ni) begin
            unique case (state_q)
                IDLE: begin
                    if (any_valid && !q_full) begin
                        aw_valid = 1'b1;
                        aw_sel   = winner;
                    end
                end
                HOLD: begin
                    aw_valid = slv_aw_valid_i[lock_q];
                    aw_sel   = lock_q;
                end
                default: begin
                    aw_valid = 1'b0;
                    aw_sel   = '0;
                end
            endcase
            if (aw_valid) begin
                slv_aw_ready_o[aw_sel] = mst_aw_ready_i;
            end
        end
    end

    assign mst_aw_valid_o = aw_valid;
    assign mst_aw_sel_o   = aw_sel;
    assign push           = aw_valid & mst_aw_ready_i;

    // W routing from the queue head only; a freshly pushed entry is visible next cycle
    always_comb begin
        mst_w_valid_o = 1'b0;
        mst_w_last_o  = 1'b0;
        mst_w_sel_o   = '0;
        slv_w_ready_o = '0;
        if (rst_ni && !q_empty) begin
            mst_w_sel_o         = head;
            mst_w_valid_o       = slv_w_valid_i[head];
            mst_w_last_o        = slv_w_last_i[head];
            slv_w_ready_o[head] = mst_w_ready_i;
        end
    end

    assign pop = mst_w_valid_o & mst_w_ready_i & mst_w_last_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= aw_sel;
        end
    end

    assign w_cnt_o = cnt_q;

endmodule

// File: tb/tb_axi_xbar_aw_w_arb.sv
// Directed bench for axi_xbar_aw_w_arb: AW grant order and W routing order
// are checked against scoreboard queues filled as stimulus is driven.
module tb_axi_xbar_aw_w_arb;

    localparam int unsigned N    = 4;
    localparam int unsigned M    = 4;
    localparam int unsigned IdxW = 2;
    localparam int unsigned CntW = 3;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic [N-1:0]    slv_aw_valid_i = '0;
    logic [N-1:0]    slv_aw_ready_o;
    logic [N-1:0]    slv_w_valid_i = '0;
    logic [N-1:0]    slv_w_last_i = '0;
    logic [N-1:0]    slv_w_ready_o;
    logic            mst_aw_valid_o;
    logic            mst_aw_ready_i = 1'b0;
    logic [IdxW-1:0] mst_aw_sel_o;
    logic            mst_w_valid_o;
    logic            mst_w_last_o;
    logic            mst_w_ready_i = 1'b0;
    logic [IdxW-1:0] mst_w_sel_o;
    logic [CntW-1:0] w_cnt_o;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned aw_exp[$];
    int unsigned w_exp[$];

    axi_xbar_aw_w_arb #(
        .NoSlvPorts(N),
        .MaxWTrans (M)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .slv_aw_valid_i(slv_aw_valid_i),
        .slv_aw_ready_o(slv_aw_ready_o),
        .slv_w_valid_i (slv_w_valid_i),
        .slv_w_last_i  (slv_w_last_i),
        .slv_w_ready_o (slv_w_ready_o),
        .mst_aw_valid_o(mst_aw_valid_o),
        .mst_aw_ready_i(mst_aw_ready_i),
        .mst_aw_sel_o  (mst_aw_sel_o),
        .mst_w_valid_o (mst_w_valid_o),
        .mst_w_last_o  (mst_w_last_o),
        .mst_w_ready_i (mst_w_ready_i),
        .mst_w_sel_o   (mst_w_sel_o),
        .w_cnt_o       (w_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // Scoreboard checks on handshakes just before the edge, then advance one cycle.
    task automatic cyc();
        int unsigned e;
        #1;
        if (mst_aw_valid_o && mst_aw_ready_i) begin
            n_tests++;
            assert (aw_exp.size() != 0) else begin
                n_fail++;
                $error("FAIL aw_unexpected: observed grant %0d expected none", mst_aw_sel_o);
            end
            if (aw_exp.size() != 0) begin
                n_tests--;
                e = aw_exp.pop_front();
                chk("aw_grant", 32'(mst_aw_sel_o), e);
            end
        end
        if (mst_w_valid_o && mst_w_ready_i && mst_w_last_o) begin
            n_tests++;
            assert (w_exp.size() != 0) else begin
                n_fail++;
                $error("FAIL w_unexpected: observed w sel %0d expected none", mst_w_sel_o);
            end
            if (w_exp.size() != 0) begin
                n_tests--;
                e = w_exp.pop_front();
                chk("w_last_sel", 32'(mst_w_sel_o), e);
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Reset with every input asserted: outputs must stay quiet
        slv_aw_valid_i = 4'hF;
        mst_aw_ready_i = 1'b1;
        slv_w_valid_i  = 4'hF;
        slv_w_last_i   = 4'hF;
        mst_w_ready_i  = 1'b1;
        settle();
        chk("rst_aw_valid", 32'(mst_aw_valid_o), 0);
        chk("rst_aw_ready", 32'(slv_aw_ready_o), 0);
        chk("rst_aw_sel", 32'(mst_aw_sel_o), 0);
        chk("rst_w_valid", 32'(mst_w_valid_o), 0);
        chk("rst_w_ready", 32'(slv_w_ready_o), 0);
        chk("rst_cnt", 32'(w_cnt_o), 0);
        cyc();
        cyc();
        slv_w_valid_i = '0;
        slv_w_last_i  = '0;
        rst_ni        = 1'b1;

        // All four ports request: grants 0,1,2,3 back to back, then queue full
        for (int unsigned i = 0; i < 4; i++) aw_exp.push_back(i);
        for (int unsigned i = 0; i < 4; i++) begin
            settle();
            chk("rr_aw_valid", 32'(mst_aw_valid_o), 1);
            cyc();
        end
        settle();
        chk("rr_cnt_full", 32'(w_cnt_o), 4);
        chk("rr_full_block", 32'(mst_aw_valid_o), 0);
        slv_aw_valid_i = '0;
        for (int unsigned i = 0; i < 4; i++) w_exp.push_back(i);
        slv_w_valid_i = 4'hF;
        slv_w_last_i  = 4'hF;
        for (int unsigned i = 0; i < 4; i++) begin
            settle();
            chk("rr_w_valid", 32'(mst_w_valid_o), 1);
            cyc();
        end
        settle();
        chk("empty_cnt", 32'(w_cnt_o), 0);
        chk("empty_w_valid", 32'(mst_w_valid_o), 0);
        chk("empty_w_sel", 32'(mst_w_sel_o), 0);
        chk("empty_w_ready", 32'(slv_w_ready_o), 0);
        slv_w_valid_i = '0;
        slv_w_last_i  = '0;

        // Port 2 held against master backpressure while port 1 joins
        slv_aw_valid_i = 4'b0100;
        mst_aw_ready_i = 1'b0;
        aw_exp.push_back(2);
        for (int unsigned i = 0; i < 3; i++) begin
            settle();
            chk("hold_sel", 32'(mst_aw_sel_o), 2);
            chk("hold_valid", 32'(mst_aw_valid_o), 1);
            chk("hold_ready_mask", 32'(slv_aw_ready_o), 0);
            cyc();
            slv_aw_valid_i = 4'b0110;
        end
        mst_aw_ready_i = 1'b1;
        settle();
        chk("hold_sel_hs", 32'(mst_aw_sel_o), 2);
        chk("hold_ready_hs", 32'(slv_aw_ready_o), 32'h4);
        cyc();
        slv_aw_valid_i = 4'b0010;
        aw_exp.push_back(1);
        settle();
        chk("after_hold_sel", 32'(mst_aw_sel_o), 1);
        cyc();
        slv_aw_valid_i = '0;
        settle();
        chk("hold_cnt", 32'(w_cnt_o), 2);
        w_exp.push_back(2);
        w_exp.push_back(1);
        slv_w_valid_i = 4'hF;
        slv_w_last_i  = 4'hF;
        cyc();
        cyc();
        slv_w_valid_i = '0;
        slv_w_last_i  = '0;

        // No fall-through; three-beat burst pops only on the last beat
        slv_w_valid_i  = 4'b0010;
        slv_aw_valid_i = 4'b0010;
        aw_exp.push_back(1);
        settle();
        chk("nft_w_valid_t", 32'(mst_w_valid_o), 0);
        chk("nft_aw_valid_t", 32'(mst_aw_valid_o), 1);
        cyc();
        slv_aw_valid_i = '0;
        settle();
        chk("nft_w_valid_t1", 32'(mst_w_valid_o), 1);
        chk("nft_w_sel_t1", 32'(mst_w_sel_o), 1);
        chk("nft_w_ready_t1", 32'(slv_w_ready_o), 32'h2);
        cyc();
        settle();
        chk("burst_cnt_b1", 32'(w_cnt_o), 1);
        cyc();
        settle();
        chk("burst_cnt_b2", 32'(w_cnt_o), 1);
        slv_w_last_i = 4'b0010;
        w_exp.push_back(1);
        cyc();
        settle();
        chk("burst_cnt_b3", 32'(w_cnt_o), 0);
        slv_w_valid_i = '0;
        slv_w_last_i  = '0;

        // Simultaneous push and pop at count 1
        slv_aw_valid_i = 4'b1000;
        aw_exp.push_back(3);
        cyc();
        slv_aw_valid_i = '0;
        settle();
        chk("pp_cnt_pre", 32'(w_cnt_o), 1);
        slv_w_valid_i  = 4'b1000;
        slv_w_last_i   = 4'b1000;
        slv_aw_valid_i = 4'b0001;
        w_exp.push_back(3);
        aw_exp.push_back(0);
        settle();
        chk("pp_w_sel", 32'(mst_w_sel_o), 3);
        chk("pp_aw_sel", 32'(mst_aw_sel_o), 0);
        cyc();
        slv_aw_valid_i = '0;
        slv_w_valid_i  = 4'b0001;
        slv_w_last_i   = '0;
        settle();
        chk("pp_cnt_post", 32'(w_cnt_o), 1);
        chk("pp_head_sel", 32'(mst_w_sel_o), 0);
        chk("pp_head_valid", 32'(mst_w_valid_o), 1);
        slv_w_last_i = 4'b0001;
        w_exp.push_back(0);
        cyc();
        slv_w_valid_i = '0;
        slv_w_last_i  = '0;
        settle();
        chk("pp_cnt_drain", 32'(w_cnt_o), 0);

        // Grants 3,0,1,2 fill the queue; 5th AW waits for the first W last
        slv_aw_valid_i = 4'b1000;
        aw_exp.push_back(3);
        cyc();
        slv_aw_valid_i = 4'b0111;
        for (int unsigned i = 0; i < 3; i++) aw_exp.push_back(i);
        cyc();
        cyc();
        cyc();
        slv_aw_valid_i = 4'b1000;
        for (int unsigned i = 0; i < 2; i++) begin
            settle();
            chk("full_aw_valid", 32'(mst_aw_valid_o), 0);
            chk("full_aw_ready", 32'(slv_aw_ready_o), 0);
            cyc();
        end
        settle();
        chk("full_cnt", 32'(w_cnt_o), 4);
        slv_w_valid_i = 4'b1000;
        slv_w_last_i  = 4'b1000;
        w_exp.push_back(3);
        settle();
        chk("full_pop_w_valid", 32'(mst_w_valid_o), 1);
        chk("full_pop_aw_valid", 32'(mst_aw_valid_o), 0);
        cyc();
        slv_w_valid_i = '0;
        slv_w_last_i  = '0;
        aw_exp.push_back(3);
        settle();
        chk("unfull_aw_valid", 32'(mst_aw_valid_o), 1);
        chk("unfull_aw_sel", 32'(mst_aw_sel_o), 3);
        cyc();
        slv_aw_valid_i = '0;
        settle();
        chk("refill_cnt", 32'(w_cnt_o), 4);

        // Asynchronous reset in HOLD, count 2, mid-burst
        slv_w_valid_i = 4'hF;
        slv_w_last_i  = 4'hF;
        w_exp.push_back(0);
        w_exp.push_back(1);
        cyc();
        cyc();
        slv_w_valid_i = '0;
        slv_w_last_i  = '0;
        settle();
        chk("ar_cnt_pre", 32'(w_cnt_o), 2);
        slv_aw_valid_i = 4'b0010;
        mst_aw_ready_i = 1'b0;
        cyc();
        slv_w_valid_i = 4'b0100;
        cyc();
        slv_w_last_i = 4'b0100;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("ar_aw_valid", 32'(mst_aw_valid_o), 0);
        chk("ar_aw_ready", 32'(slv_aw_ready_o), 0);
        chk("ar_aw_sel", 32'(mst_aw_sel_o), 0);
        chk("ar_w_valid", 32'(mst_w_valid_o), 0);
        chk("ar_w_last", 32'(mst_w_last_o), 0);
        chk("ar_w_ready", 32'(slv_w_ready_o), 0);
        chk("ar_w_sel", 32'(mst_w_sel_o), 0);
        chk("ar_cnt", 32'(w_cnt_o), 0);
        w_exp.delete();
        cyc();
        slv_aw_valid_i = 4'b1010;
        mst_aw_ready_i = 1'b1;
        slv_w_valid_i  = '0;
        slv_w_last_i   = '0;
        #2;
        rst_ni = 1'b1;
        aw_exp.push_back(1);
        settle();
        chk("post_rst_sel", 32'(mst_aw_sel_o), 1);
        cyc();
        slv_aw_valid_i = '0;
        settle();
        chk("post_rst_cnt", 32'(w_cnt_o), 1);
        chk("aw_sb_drained", 32'(aw_exp.size()), 0);
        chk("w_sb_drained", 32'(w_exp.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
